alu_writeback: RTL
==================

Name: alu_writeback

Overview:
Downstream stage of the 16-bit CR16 ALU. It captures the ALU Result and Flags on a valid strobe and writes Result into a 16-entry register file. It updates the 5-bit processor status register (PSR) using a per-opcode flag mask. It also supplies the two operand read ports and the stored carry that feed the ALU's Rdest/Rsrc_Imm inputs on the next operation.

Parameters:
DATA_W, 16, register and Result width
NUM_REGS, 16, register file depth
ADDR_W, 4, register address width (log2 NUM_REGS)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
wb_valid  in  1  Result/Flags/wb_opcode/wb_dest valid this cycle
wb_opcode  in  8  opcode that produced Result (same encoding as ALU Opcode)
wb_dest  in  ADDR_W  destination register index
wb_result  in  DATA_W  ALU Result
wb_flags  in  5  ALU Flags: [4]=L, [3]=C, [2]=F, [1]=Z, [0]=N
psr_we  in  1  software PSR load (context restore)
psr_wdata  in  5  PSR load value
rd_a_addr  in  ADDR_W  read port A index (feeds ALU Rdest)
rd_b_addr  in  ADDR_W  read port B index (feeds ALU Rsrc)
rd_a_data  out  DATA_W  port A data
rd_b_data  out  DATA_W  port B data
psr  out  5  current PSR
carry_in  out  1  psr[3], for ADDC/SUBC
retire_cnt  out  16  count of retired legal non-WAIT ops
illegal_op  out  1  one-cycle pulse on an undefined opcode

Behaviour:
- Reset (asynchronous, reset_n=0): all registers 0, psr=0, retire_cnt=0, illegal_op=0. This takes effect immediately, including mid-operation. The first edge after deassertion behaves normally.
- All state updates on the rising edge of clk when wb_valid=1. When wb_valid=0: no register write, no PSR change, counter holds, illegal_op=0.
- Opcode classes, with register-write (RW) and flag mask (bits updated from wb_flags; other bits hold):
  - Arithmetic (ADD 0x05, ADDU 0x06, ADDC 0x07, ADDI 0x50, ADDUI 0x60, ADDCI 0x70, SUB 0x09, SUBC 0x0A, SUBI 0x90, SUBCI 0xA0): RW=1, mask=L,C,F,Z,N.
  - Compare (CMP 0x0B, CMPI 0xB0): RW=0, mask=L,C,F,Z,N.
  - Multiply (MUL 0x0E, MULI 0xE0): RW=1, mask=C,Z,N.
  - Logic, move and shift (AND 0x01, OR 0x02, XOR 0x03, NOT 0x04, MOV 0x0D, MOVI 0xD0, LSH 0x0C, LSHI 0xC0, RSH 0x08, RSHI 0x80, ARSH 0x0F, ARSHI 0xF0): RW=1, mask=Z,N.
  - WAIT (0x00): RW=0, mask none, counter holds.
  - Any other value: RW=0, mask none, counter holds. illegal_op=1 for exactly the following cycle (registered).
- Write latency: a register written at edge N is visible on the read ports from edge N onward.
- Read ports are combinational with a same-cycle bypass. If wb_valid=1, RW=1 and rd_x_addr==wb_dest, then rd_x_data=wb_result; otherwise rd_x_data is array contents. Both ports may bypass simultaneously.
- PSR priority: if psr_we=1 on the same edge as a flag-updating wb, psr=psr_wdata and wb flags are discarded. The register write and counter increment still occur. psr_we alone loads psr regardless of wb_valid.
- carry_in is psr[3], registered, with no bypass.
- retire_cnt increments by 1 per accepted legal non-WAIT op, CMP included. It wraps 0xFFFF -> 0x0000 without flagging.
- All register indices 0..NUM_REGS-1 are writable; R0 is not hard-wired.
- Back-to-back wb_valid every cycle is supported, with no stall and no ready signal.

Test Plan:
- Reset mid-stream: write R3=0x1234, assert reset_n=0 between edges -> rd_a(3)=0x0000, psr=0, retire_cnt=0 immediately, without waiting for a clock edge.
- ADD then CMP: ADD dest=R2, result=0x8000, flags=0b00101 -> R2=0x8000, psr=0b00101. Then CMP, flags=0b10010 -> psr=0b10010, R2 unchanged, retire_cnt=2.
- Partial mask: psr=0b11111, AND result=0x0001, flags=0b00000 -> psr=0b11100. Then MUL, flags=0b01010 -> psr=0b11110.
- Bypass: wb_valid=1, ADDU dest=R5, result=0xBEEF, rd_a_addr=rd_b_addr=5 in the same cycle -> both ports read 0xBEEF before the edge. With wb_opcode=CMP instead -> both ports read the old R5.
- Illegal/WAIT and priority: opcode 0x11 -> illegal_op pulses 1 cycle, no write, counter holds. WAIT -> no change. ADD with flags=0b00010 plus psr_we=1, psr_wdata=0b01000 -> psr=0b01000, carry_in=1, register written.
- Counter wrap: preload via 65535 MOVs -> retire_cnt=0xFFFF. One more MOV -> 0x0000.

Source files
------------

// File: rtl/alu_writeback.sv
// Writeback stage behind the CR16 ALU: register file, PSR flag merge, retire counter and
// illegal-opcode pulse. Read ports bypass the in-flight writeback so the ALU sees fresh operands.
module alu_writeback #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wb_valid,
    input  logic [7:0]        wb_opcode,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_result,
    input  logic [4:0]        wb_flags,
    input  logic              psr_we,
    input  logic [4:0]        psr_wdata,
    input  logic [ADDR_W-1:0] rd_a_addr,
    input  logic [ADDR_W-1:0] rd_b_addr,
    output logic [DATA_W-1:0] rd_a_data,
    output logic [DATA_W-1:0] rd_b_data,
    output logic [4:0]        psr,
    output logic              carry_in,
    output logic [15:0]       retire_cnt,
    output logic              illegal_op
);

    // PSR bit order: [4]=L [3]=C [2]=F [1]=Z [0]=N
    localparam logic [4:0] MASK_ALL   = 5'b11111;
    localparam logic [4:0] MASK_MUL   = 5'b01011;
    localparam logic [4:0] MASK_LOGIC = 5'b00011;
    localparam logic [4:0] MASK_NONE  = 5'b00000;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [4:0]        psr_q, psr_d;
    logic [15:0]       retire_q, retire_d;
    logic              illegal_q, illegal_d;

    logic       op_rw;
    logic       op_legal;
    logic       op_retire;
    logic [4:0] op_mask;
    logic       reg_we;

    always_comb begin
        op_rw     = 1'b0;
        op_legal  = 1'b1;
        op_retire = 1'b1;
        op_mask   = MASK_NONE;
        case (wb_opcode)
            8'h05, 8'h06, 8'h07, 8'h50, 8'h60,
            8'h70, 8'h09, 8'h0A, 8'h90, 8'hA0: begin
                op_rw   = 1'b1;
                op_mask = MASK_ALL;
            end
            8'h0B, 8'hB0: begin
                op_mask = MASK_ALL;
            end
            8'h0E, 8'hE0: begin
                op_rw   = 1'b1;
                op_mask = MASK_MUL;
            end
            8'h01, 8'h02, 8'h03, 8'h04, 8'h0D, 8'hD0,
            8'h0C, 8'hC0, 8'h08, 8'h80, 8'h0F, 8'hF0: begin
                op_rw   = 1'b1;
                op_mask = MASK_LOGIC;
            end
            8'h00: begin
                op_retire = 1'b0;
            end
            default: begin
                op_legal  = 1'b0;
                op_retire = 1'b0;
            end
        endcase
    end

    assign reg_we = wb_valid && op_rw;

    always_comb begin
        psr_d     = psr_q;
        retire_d  = retire_q;
        illegal_d = 1'b0;
        // A software PSR load overrides any flag update landing on the same edge.
        if (psr_we) begin
            psr_d = psr_wdata;
        end else if (wb_valid) begin
            psr_d = (psr_q & ~op_mask) | (wb_flags & op_mask);
        end
        if (wb_valid) begin
            if (op_retire) begin
                retire_d = retire_q + 16'd1;
            end
            illegal_d = ~op_legal;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            psr_q     <= '0;
            retire_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (reg_we) begin
                regs_q[wb_dest] <= wb_result;
            end
            psr_q     <= psr_d;
            retire_q  <= retire_d;
            illegal_q <= illegal_d;
        end
    end

    assign rd_a_data  = (reg_we && (rd_a_addr == wb_dest)) ? wb_result : regs_q[rd_a_addr];
    assign rd_b_data  = (reg_we && (rd_b_addr == wb_dest)) ? wb_result : regs_q[rd_b_addr];
    assign psr        = psr_q;
    assign carry_in   = psr_q[3];
    assign retire_cnt = retire_q;
    assign illegal_op = illegal_q;

endmodule
